// File: rtl/if_fetch_unit_pkg.sv
// Shared widths, defaults and the fetch-entry payload for the instruction fetch stage.
package if_fetch_unit_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned INSTR_W = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   // Sequential word address, wrapping modulo 2^32.
   function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
      return pc + XLEN'(4);
   endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// Synchronous fetch FIFO with flush and same-cycle push/pop (also when full).
module if_fetch_fifo
   import if_fetch_unit_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  fetch_entry_t               din,
   input  logic                       pop,
   output fetch_entry_t               dout,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   fetch_entry_t   mem [DEPTH];
   logic [AW-1:0]  rd_ptr;
   logic [AW-1:0]  wr_ptr;
   logic           do_pop;

   assign empty  = (count == '0);
   assign full   = (count == CW'(DEPTH));
   assign do_pop = pop & ~empty;
   assign dout   = empty ? '0 : mem[rd_ptr];

   // Pointers and occupancy; flush empties the queue without touching storage.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !flush && push) mem[wr_ptr] <= din;
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop))
      else $error("if_fetch_fifo: push into full FIFO");

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, issues credit-limited in-order fetches and feeds decode.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned     DEPTH    = 2
) (
   input  logic                clk,
   input  logic                rst,
   output logic                imem_req_valid,
   input  logic                imem_req_ready,
   output logic [XLEN-1:0]     imem_req_addr,
   input  logic                imem_rsp_valid,
   input  logic [INSTR_W-1:0]  imem_rsp_data,
   input  logic                redirect_valid,
   input  logic [XLEN-1:0]     redirect_pc,
   output logic                id_valid,
   input  logic                id_ready,
   output logic [XLEN-1:0]     id_pc,
   output logic [INSTR_W-1:0]  id_instr
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned SUM_W = CNT_W + 1;

   logic [XLEN-1:0]   pc_q;
   logic [XLEN-1:0]   rsp_pc_q;
   logic [CNT_W-1:0]  outstanding_q;
   logic [CNT_W-1:0]  drop_q;
   logic              live_q;

   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_empty;
   logic              fifo_full;
   fetch_entry_t      fifo_head;
   fetch_entry_t      fifo_din;

   logic              credit_ok;
   logic              accept;
   logic              push;
   logic              pop;
   logic [XLEN-1:0]   target_pc;

   assign target_pc = redirect_pc & ~XLEN'(3);
   assign credit_ok = (SUM_W'(outstanding_q) + SUM_W'(fifo_count)) < SUM_W'(DEPTH);

   // live_q holds off issue for one idle cycle after reset release.
   assign imem_req_valid = live_q & ~rst & ~redirect_valid & credit_ok;
   assign imem_req_addr  = pc_q;
   assign accept         = imem_req_valid & imem_req_ready;

   assign push     = imem_rsp_valid & ~rst & ~redirect_valid & (drop_q == '0);
   assign fifo_din = '{pc: rsp_pc_q, instr: imem_rsp_data};

   assign id_valid = ~fifo_empty & ~redirect_valid & ~rst;
   assign pop      = id_valid & id_ready;
   assign id_pc    = fifo_head.pc;
   assign id_instr = fifo_head.instr;

   // PC, response PC, credit and stale-response bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         outstanding_q <= '0;
         drop_q        <= '0;
         live_q        <= 1'b0;
      end else begin
         live_q <= 1'b1;
         if (redirect_valid) begin
            pc_q     <= target_pc;
            rsp_pc_q <= target_pc;
            drop_q   <= outstanding_q - CNT_W'(imem_rsp_valid);
         end else begin
            if (accept) pc_q <= next_pc(pc_q);
            if (push) rsp_pc_q <= next_pc(rsp_pc_q);
            if (imem_rsp_valid && drop_q != '0) drop_q <= drop_q - CNT_W'(1);
         end
         case ({accept, imem_rsp_valid})
            2'b10:   outstanding_q <= outstanding_q + CNT_W'(1);
            2'b01:   outstanding_q <= outstanding_q - CNT_W'(1);
            default: outstanding_q <= outstanding_q;
         endcase
      end
   end

   if_fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (redirect_valid),
      .push  (push),
      .din   (fifo_din),
      .pop   (pop),
      .dout  (fifo_head),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   a_full_means_no_credit: assert property (@(posedge clk) disable iff (rst)
      fifo_full |-> !imem_req_valid)
      else $error("if_fetch_unit: request issued with full FIFO");

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit with a queue-based reference model and in-order memory.
module tb_if_fetch_unit;

   localparam int unsigned   DEPTH    = 2;
   localparam logic [31:0]   RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_instr;

   if_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_pc          (id_pc),
      .id_instr       (id_instr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: architectural view of the fetch stage.
   logic [31:0] m_pc, m_rpc;
   int          m_out, m_drop;
   bit          m_live;
   logic [63:0] mq[$];
   logic [31:0] pend[$];
   logic [31:0] salt;

   bit          e_rv, e_iv;
   logic [31:0] e_addr;
   logic [63:0] e_head;

   // Drive one cycle's inputs at negedge and derive the expected outputs.
   task automatic drive(input bit r, input bit rd, input logic [31:0] rpc,
                        input bit idr, input bit rdy, input int rmode);
      bit rv;
      @(negedge clk);
      rv = (pend.size() > 0) && (rmode == 1 || (rmode == 2 && $urandom_range(1) == 1));
      rst            = r;
      redirect_valid = rd;
      redirect_pc    = rpc;
      id_ready       = idr;
      imem_req_ready = rdy;
      imem_rsp_valid = rv;
      imem_rsp_data  = rv ? (pend[0] ^ salt) : $urandom;
      #1;
      e_rv   = !r && !rd && m_live && (m_out + mq.size() < DEPTH);
      e_addr = m_pc;
      e_iv   = !r && !rd && (mq.size() > 0);
      e_head = (mq.size() > 0) ? mq[0] : 64'd0;
   endtask

   // Apply the clock edge to the model using the inputs currently driven.
   task automatic advance();
      bit acc;
      if (rst) begin
         m_pc = RESET_PC; m_rpc = RESET_PC; m_out = 0; m_drop = 0; m_live = 0;
         mq.delete(); pend.delete();
      end else begin
         m_live = 1;
         if (imem_rsp_valid) void'(pend.pop_front());
         if (redirect_valid) begin
            m_drop = m_out - int'(imem_rsp_valid);
            m_out  = m_drop;
            mq.delete();
            m_pc   = redirect_pc & ~32'd3;
            m_rpc  = m_pc;
         end else begin
            acc = e_rv && imem_req_ready;
            if (e_iv && id_ready) void'(mq.pop_front());
            if (imem_rsp_valid) begin
               if (m_drop > 0) m_drop--;
               else begin
                  mq.push_back({m_rpc, imem_rsp_data});
                  m_rpc = m_rpc + 32'd4;
               end
            end
            m_out = m_out + int'(acc) - int'(imem_rsp_valid);
            if (acc) begin
               pend.push_back(m_pc);
               m_pc = m_pc + 32'd4;
            end
         end
      end
   endtask

   task automatic test_reset();
      int first;
      first = -1;
      for (int i = 0; i < 2; i++) begin
         drive(1, 0, 0, 1, 1, 1);
         n_cmp += 2;
         if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: req_valid=%b id_valid=%b want 0 0", imem_req_valid, id_valid);
         end
         if (i == 1 && {id_pc, id_instr} !== 64'd0) begin
            n_fail++; $display("FAIL reset_head: got %h want 0", {id_pc, id_instr});
         end
         advance();
      end
      for (int k = 0; k < 12; k++) begin
         drive(0, 0, 0, 1, 1, 1);
         n_cmp += 2;
         if (imem_req_valid !== e_rv || imem_req_addr !== e_addr) begin
            n_fail++; $display("FAIL reset_req k=%0d: got %b/%h want %b/%h", k, imem_req_valid, imem_req_addr, e_rv, e_addr);
         end
         if (id_valid !== e_iv || {id_pc, id_instr} !== e_head) begin
            n_fail++; $display("FAIL reset_id k=%0d: got %b/%h want %b/%h", k, id_valid, {id_pc, id_instr}, e_iv, e_head);
         end
         if (id_valid === 1'b1 && first < 0) first = k;
         advance();
      end
      n_cmp++;
      if (first !== 3) begin
         n_fail++; $display("FAIL first_id_latency: got %0d want 3", first);
      end
   endtask

   task automatic test_stall();
      for (int k = 0; k < 14; k++) begin
         drive(0, 0, 0, !(k >= 3 && k < 8), 1, 1);
         n_cmp += 2;
         if (imem_req_valid !== e_rv || imem_req_addr !== e_addr) begin
            n_fail++; $display("FAIL stall_req k=%0d: got %b/%h want %b/%h", k, imem_req_valid, imem_req_addr, e_rv, e_addr);
         end
         if (id_valid !== e_iv || {id_pc, id_instr} !== e_head) begin
            n_fail++; $display("FAIL stall_id k=%0d: got %b/%h want %b/%h", k, id_valid, {id_pc, id_instr}, e_iv, e_head);
         end
         advance();
      end
   endtask

   task automatic test_redirect();
      logic [31:0] seen;
      bit          got;
      got = 0; seen = 32'hx;
      // Build two in-flight requests with the memory silent.
      for (int k = 0; k < 4; k++) begin drive(0, 0, 0, 1, 1, 0); advance(); end
      drive(0, 1, 32'h100, 1, 1, 0);
      n_cmp += 2;
      if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
         n_fail++; $display("FAIL redirect_cycle: id_valid=%b req_valid=%b want 0 0", id_valid, imem_req_valid);
      end
      if (m_out != 2) begin
         n_fail++; $display("FAIL redirect_inflight: got %0d want 2", m_out);
      end
      advance();
      // Back-to-back redirects: the second one wins.
      drive(0, 1, 32'h180, 1, 1, 1); advance();
      drive(0, 1, 32'h100, 1, 1, 0); advance();
      for (int k = 0; k < 10; k++) begin
         drive(0, 0, 0, 1, 1, 1);
         n_cmp += 2;
         if (imem_req_valid !== e_rv || imem_req_addr !== e_addr) begin
            n_fail++; $display("FAIL redir_req k=%0d: got %b/%h want %b/%h", k, imem_req_valid, imem_req_addr, e_rv, e_addr);
         end
         if (id_valid !== e_iv || {id_pc, id_instr} !== e_head) begin
            n_fail++; $display("FAIL redir_id k=%0d: got %b/%h want %b/%h", k, id_valid, {id_pc, id_instr}, e_iv, e_head);
         end
         if (id_valid === 1'b1 && !got) begin got = 1; seen = id_pc; end
         advance();
      end
      n_cmp++;
      if (seen !== 32'h100) begin
         n_fail++; $display("FAIL redirect_target: got %h want 00000100", seen);
      end
   endtask

   task automatic test_redirect_rsp();
      logic [31:0] seen;
      bit          got;
      got = 0; seen = 32'hx;
      for (int k = 0; k < 4; k++) begin drive(0, 0, 0, 1, 1, 0); advance(); end
      drive(0, 1, 32'h203, 1, 1, 1);
      n_cmp++;
      if (imem_rsp_valid !== 1'b1 || id_valid !== 1'b0) begin
         n_fail++; $display("FAIL redirect_rsp_cycle: rsp=%b id_valid=%b want 1 0", imem_rsp_valid, id_valid);
      end
      advance();
      for (int k = 0; k < 10; k++) begin
         drive(0, 0, 0, 1, 1, 1);
         n_cmp += 2;
         if (imem_req_valid !== e_rv || imem_req_addr !== e_addr) begin
            n_fail++; $display("FAIL redir_rsp_req k=%0d: got %b/%h want %b/%h", k, imem_req_valid, imem_req_addr, e_rv, e_addr);
         end
         if (id_valid !== e_iv || {id_pc, id_instr} !== e_head) begin
            n_fail++; $display("FAIL redir_rsp_id k=%0d: got %b/%h want %b/%h", k, id_valid, {id_pc, id_instr}, e_iv, e_head);
         end
         if (id_valid === 1'b1 && !got) begin got = 1; seen = id_pc; end
         advance();
      end
      n_cmp++;
      if (seen !== 32'h200) begin
         n_fail++; $display("FAIL redirect_align: got %h want 00000200", seen);
      end
   endtask

   task automatic test_req_backpressure();
      for (int k = 0; k < 10; k++) begin
         drive(0, 0, 0, 1, !(k >= 2 && k < 6), 1);
         n_cmp += 2;
         if (imem_req_valid !== e_rv || imem_req_addr !== e_addr) begin
            n_fail++; $display("FAIL reqbp_req k=%0d: got %b/%h want %b/%h", k, imem_req_valid, imem_req_addr, e_rv, e_addr);
         end
         if (id_valid !== e_iv || {id_pc, id_instr} !== e_head) begin
            n_fail++; $display("FAIL reqbp_id k=%0d: got %b/%h want %b/%h", k, id_valid, {id_pc, id_instr}, e_iv, e_head);
         end
         advance();
      end
   endtask

   task automatic test_reset_midstream();
      logic [31:0] seen;
      bit          got;
      int          guard;
      got = 0; seen = 32'hx; guard = 0;
      while (mq.size() < DEPTH && guard < 12) begin
         drive(0, 0, 0, 0, 1, 1); advance(); guard++;
      end
      n_cmp++;
      if (id_valid !== 1'b1 || mq.size() != DEPTH) begin
         n_fail++; $display("FAIL fill_before_reset: id_valid=%b entries=%0d want 1 %0d", id_valid, mq.size(), DEPTH);
      end
      drive(1, 0, 0, 0, 1, 1); advance();
      drive(0, 0, 0, 1, 1, 1);
      n_cmp++;
      if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
         n_fail++; $display("FAIL after_reset: id_valid=%b req_valid=%b want 0 0", id_valid, imem_req_valid);
      end
      advance();
      for (int k = 0; k < 8; k++) begin
         drive(0, 0, 0, 1, 1, 1);
         if (id_valid === 1'b1 && !got) begin got = 1; seen = id_pc; end
         advance();
      end
      n_cmp++;
      if (seen !== RESET_PC) begin
         n_fail++; $display("FAIL resume_pc: got %h want %h", seen, RESET_PC);
      end
   endtask

   task automatic test_random();
      logic [31:0] rpc;
      for (int k = 0; k < 600; k++) begin
         rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'h0000_FFFF);
         drive($urandom_range(99) == 0, $urandom_range(15) == 0, rpc,
               $urandom_range(3) != 0, $urandom_range(3) != 0, 2);
         n_cmp += 2;
         if (imem_req_valid !== e_rv || imem_req_addr !== e_addr) begin
            n_fail++; $display("FAIL rand_req k=%0d: got %b/%h want %b/%h", k, imem_req_valid, imem_req_addr, e_rv, e_addr);
         end
         if (id_valid !== e_iv || {id_pc, id_instr} !== e_head) begin
            n_fail++; $display("FAIL rand_id k=%0d: got %b/%h want %b/%h", k, id_valid, {id_pc, id_instr}, e_iv, e_head);
         end
         advance();
      end
   endtask

   initial begin
      salt = $urandom;
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      m_pc = RESET_PC; m_rpc = RESET_PC; m_out = 0; m_drop = 0; m_live = 0;
      test_reset();
      test_stall();
      test_redirect();
      test_redirect_rsp();
      test_req_backpressure();
      test_reset_midstream();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
